hub75_scan_scheduler: RTL and testbench

Sequences refresh of the HUB75 panel: walks row address × bit-plane, commands the column shifter to load each plane, and drives blanking, latch and address so rows never change while lit. Binary-coded modulation gives RGB_RES/3 bits per colour channel. Shifting of the next plane overlaps display of the current one. Sits between frame_manager/hub75_output and the panel pins, replacing the free-running address assignment at top level.

---
 rtl/hub75_pkg.sv | 18 +
 rtl/plane_timer.sv | 29 ++
 rtl/hub75_scan_scheduler.sv | 173 +++++++++++++++++
 tb/tb_hub75_scan_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared scan states and default panel geometry for the HUB75 path
package hub75_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SHIFT,
        ST_BLANK,
        ST_LATCH,
        ST_DISPLAY
    } state_t;

    localparam int SCAN_RATE_DEF = 32;
    localparam int RGB_RES_DEF   = 9;
    localparam int PLANES        = RGB_RES_DEF / 3;
    localparam int ADDR_W        = $clog2(SCAN_RATE_DEF);
    localparam int PLANE_W       = $clog2(PLANES);

endpackage

// File: rtl/plane_timer.sv
// rtl/plane_timer.sv - loadable down-counter timing blank and lit intervals
module plane_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired,
    output logic         last
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // last marks the final counted cycle so the FSM can leave without a dead cycle
    assign expired = (count == '0);
    assign last    = (count <= W'(1));

endmodule

// File: rtl/hub75_scan_scheduler.sv
// rtl/hub75_scan_scheduler.sv - row x bit-plane refresh sequencer with overlapped shifting
module hub75_scan_scheduler
    import hub75_pkg::*;
#(
    parameter int  SCAN_RATE   = SCAN_RATE_DEF,
    parameter int  RGB_RES     = RGB_RES_DEF,
    parameter int  ON_BASE     = 8,
    parameter int  DEAD_CYCLES = 2,
    localparam int NUM_PLANES  = RGB_RES / 3,
    localparam int ROW_W       = $clog2(SCAN_RATE),
    localparam int PL_W        = $clog2(NUM_PLANES),
    localparam int TMR_W       = $clog2(ON_BASE << (NUM_PLANES - 1)) + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             enable_in,
    input  logic             frame_sync_in,
    output logic             shift_start_out,
    output logic [ROW_W-1:0] shift_row_out,
    output logic [PL_W-1:0]  shift_plane_out,
    input  logic             shift_done_in,
    output logic [ROW_W-1:0] hub75_addr_out,
    output logic             hub75_latch_out,
    output logic             hub75_oe_n_out,
    output logic             frame_done_out,
    output logic             busy_out
);

    state_t             state;
    state_t             state_next;
    logic [ROW_W-1:0]   disp_row;
    logic [PL_W-1:0]    disp_plane;
    logic [ROW_W-1:0]   next_row;
    logic [PL_W-1:0]    next_plane;
    logic               done_flag;
    logic               sync_pend;
    logic               disp_last;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_expired;
    logic               tmr_last;
    logic               issue_first;
    logic               issue_next;
    logic               capture;
    logic               load_addr;

    plane_timer #(.W(TMR_W)) u_timer (
        .clk      (clk_in),
        .rst_n    (rst_in),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired),
        .last     (tmr_last)
    );

    always_comb begin
        next_row   = disp_row;
        next_plane = disp_plane + 1'b1;
        if (disp_plane == PL_W'(NUM_PLANES - 1)) begin
            next_plane = '0;
            next_row   = (disp_row == ROW_W'(SCAN_RATE - 1)) ? '0 : disp_row + 1'b1;
        end
    end

    assign disp_last = (disp_row == ROW_W'(SCAN_RATE - 1)) &&
                       (disp_plane == PL_W'(NUM_PLANES - 1));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        tmr_load       = 1'b0;
        tmr_val        = '0;
        issue_first    = 1'b0;
        issue_next     = 1'b0;
        capture        = 1'b0;
        load_addr      = 1'b0;
        frame_done_out = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable_in) begin
                    state_next  = ST_WAIT_SHIFT;
                    issue_first = 1'b1;
                end
            end
            ST_WAIT_SHIFT: begin
                if (shift_done_in) begin
                    state_next = ST_BLANK;
                    capture    = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = TMR_W'(DEAD_CYCLES);
                end
            end
            ST_BLANK: begin
                if (tmr_last) begin
                    state_next = ST_LATCH;
                    load_addr  = 1'b1;
                end
            end
            ST_LATCH: begin
                state_next = ST_DISPLAY;
                issue_next = 1'b1;
                tmr_load   = 1'b1;
                tmr_val    = TMR_W'(ON_BASE << disp_plane);
            end
            ST_DISPLAY: begin
                // lit time is fixed by the timer; a late shifter only lengthens the dark tail
                if (tmr_last && (done_flag || shift_done_in)) begin
                    frame_done_out = disp_last;
                    if (enable_in) begin
                        state_next = ST_BLANK;
                        capture    = 1'b1;
                        tmr_load   = 1'b1;
                        tmr_val    = TMR_W'(DEAD_CYCLES);
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            shift_start_out <= 1'b0;
            shift_row_out   <= '0;
            shift_plane_out <= '0;
            disp_row        <= '0;
            disp_plane      <= '0;
            hub75_addr_out  <= '0;
            done_flag       <= 1'b0;
            sync_pend       <= 1'b0;
        end else begin
            shift_start_out <= issue_first | issue_next;
            if (issue_first || (issue_next && (sync_pend || frame_sync_in))) begin
                shift_row_out   <= '0;
                shift_plane_out <= '0;
            end else if (issue_next) begin
                shift_row_out   <= next_row;
                shift_plane_out <= next_plane;
            end
            if (capture) begin
                disp_row   <= shift_row_out;
                disp_plane <= shift_plane_out;
            end
            if (load_addr) begin
                hub75_addr_out <= disp_row;
            end
            if (issue_next) begin
                done_flag <= 1'b0;
            end else if (state == ST_DISPLAY && shift_done_in) begin
                done_flag <= 1'b1;
            end
            if (state == ST_IDLE || issue_next) begin
                sync_pend <= 1'b0;
            end else if (frame_sync_in) begin
                sync_pend <= 1'b1;
            end
        end
    end

    assign hub75_latch_out = (state == ST_LATCH);
    assign hub75_oe_n_out  = !((state == ST_DISPLAY) && !tmr_expired);
    assign busy_out        = (state != ST_IDLE);

endmodule

// File: tb/tb_hub75_scan_scheduler.sv
// tb/tb_hub75_scan_scheduler.sv - scoreboard bench for hub75_scan_scheduler
module tb_hub75_scan_scheduler;
    import hub75_pkg::*;

    localparam int SCAN = 32;
    localparam int NPL  = 3;
    localparam int ON   = 8;
    localparam int DEAD = 2;

    typedef struct {
        int row;
        int plane;
        int fd;
    } vis_t;

    logic               clk = 1'b0;
    logic               rst_in = 1'b0;
    logic               enable_in = 1'b0;
    logic               frame_sync_in = 1'b0;
    logic               shift_done_in = 1'b0;
    logic               shift_start_out;
    logic [ADDR_W-1:0]  shift_row_out;
    logic [PLANE_W-1:0] shift_plane_out;
    logic [ADDR_W-1:0]  hub75_addr_out;
    logic               hub75_latch_out;
    logic               hub75_oe_n_out;
    logic               frame_done_out;
    logic               busy_out;

    int   total = 0;
    int   bad = 0;
    int   shift_lat = 20;
    bit   rand_lat = 0;
    bit   fast = 0;
    int   n_latch = 0;
    int   cur_lat;
    vis_t exp_shift[$];
    vis_t exp_disp[$];

    hub75_scan_scheduler #(
        .SCAN_RATE   (SCAN),
        .RGB_RES     (9),
        .ON_BASE     (ON),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst_in),
        .enable_in       (enable_in),
        .frame_sync_in   (frame_sync_in),
        .shift_start_out (shift_start_out),
        .shift_row_out   (shift_row_out),
        .shift_plane_out (shift_plane_out),
        .shift_done_in   (shift_done_in),
        .hub75_addr_out  (hub75_addr_out),
        .hub75_latch_out (hub75_latch_out),
        .hub75_oe_n_out  (hub75_oe_n_out),
        .frame_done_out  (frame_done_out),
        .busy_out        (busy_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input bit ok, input longint act, input longint req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endtask

    task automatic chk_eq(input string nm, input longint act, input longint req);
        chk(nm, act == req, act, req);
    endtask

    // shifter: answers each load request after a programmable latency
    initial begin
        forever begin
            @(negedge clk);
            if (rst_in && shift_start_out) begin
                cur_lat = rand_lat ? int'($urandom_range(60, 1)) : shift_lat;
                for (int i = 1; i < cur_lat && rst_in; i++) @(negedge clk);
                if (rst_in) begin
                    shift_done_in = 1'b1;
                    @(negedge clk);
                    shift_done_in = 1'b0;
                end
            end
        end
    end

    bit   vis_active = 0;
    int   vis_addr, lit_cnt, lit_runs, fd_seen;
    int   high_run = 0;
    int   gap = 0;
    bit   idle_in_gap = 1;
    logic prev_oe = 1'b1;
    logic prev_latch = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;

    task automatic finalize();
        vis_t e;
        if (exp_disp.size() == 0) begin
            chk("unexpected_display", 0, vis_addr, -1);
        end else begin
            e = exp_disp.pop_front();
            chk_eq("disp_row", vis_addr, e.row);
            chk_eq("lit_cycles", lit_cnt, ON << e.plane);
            chk_eq("lit_runs", lit_runs, 1);
            chk_eq("frame_done", fd_seen, e.fd);
        end
        vis_active = 0;
    endtask

    initial begin
        vis_t e;
        forever begin
            @(negedge clk);
            if (!rst_in) begin
                vis_active  = 0;
                high_run    = 0;
                gap         = 0;
                idle_in_gap = 1;
                prev_oe     = 1'b1;
                prev_latch  = 1'b0;
                prev_addr   = '0;
            end else begin
                if (shift_start_out) begin
                    if (exp_shift.size() == 0) begin
                        chk("unexpected_shift", 0, shift_row_out, -1);
                    end else begin
                        e = exp_shift.pop_front();
                        chk_eq("shift_row", shift_row_out, e.row);
                        chk_eq("shift_plane", shift_plane_out, e.plane);
                    end
                    if (prev_latch) chk_eq("shift_with_lit", hub75_oe_n_out, 0);
                end
                if (hub75_addr_out != prev_addr) chk_eq("addr_change_in_latch", hub75_latch_out, 1);
                if (frame_done_out && vis_active) fd_seen++;
                if (hub75_latch_out) begin
                    if (vis_active) finalize();
                    chk_eq("latch_oe_n", hub75_oe_n_out, 1);
                    chk("blank_before_latch", high_run >= DEAD, high_run, DEAD);
                    n_latch++;
                    vis_active = 1;
                    vis_addr   = int'(hub75_addr_out);
                    lit_cnt    = 0;
                    lit_runs   = 0;
                    fd_seen    = 0;
                end
                if (!hub75_oe_n_out) begin
                    if (prev_oe && !idle_in_gap) begin
                        chk("dark_gap_min", gap >= DEAD + 1, gap, DEAD + 1);
                        if (fast) chk_eq("dark_gap_fast", gap, DEAD + 1);
                    end
                    if (prev_oe) lit_runs++;
                    lit_cnt++;
                    high_run    = 0;
                    gap         = 0;
                    idle_in_gap = 0;
                end else begin
                    high_run++;
                    gap++;
                end
                if (!busy_out) begin
                    idle_in_gap = 1;
                    if (vis_active) finalize();
                end
                prev_oe    = hub75_oe_n_out;
                prev_latch = hub75_latch_out;
                prev_addr  = hub75_addr_out;
            end
        end
    end

    // visit i of a run shows (i/NPL mod SCAN, i mod NPL); a sync seen during visit k restarts at visit k+2
    task automatic build(input int n, input int sync_at);
        for (int i = 0; i <= n; i++) begin
            int   idx;
            vis_t v;
            idx     = (sync_at >= 0 && i >= sync_at + 2) ? i - (sync_at + 2) : i;
            v.row   = (idx / NPL) % SCAN;
            v.plane = idx % NPL;
            v.fd    = (v.row == SCAN - 1 && v.plane == NPL - 1) ? 1 : 0;
            exp_shift.push_back(v);
            if (i < n) exp_disp.push_back(v);
        end
    endtask

    task automatic wait_latches(input int target, input int limit);
        int c = 0;
        while (n_latch < target && c < limit) begin
            @(negedge clk);
            c++;
        end
        chk("latch_reached", n_latch >= target, n_latch, target);
    endtask

    task automatic wait_idle(input int limit);
        int c = 0;
        while (busy_out && c < limit) begin
            @(negedge clk);
            c++;
        end
        chk_eq("idle_reached", busy_out, 0);
    endtask

    task automatic start_run(input int n, input int sync_at, output int base);
        build(n, sync_at);
        base = n_latch;
        @(negedge clk);
        enable_in = 1'b1;
        @(negedge clk);
        chk_eq("start_next_cycle", shift_start_out, 1);
    endtask

    task automatic run_seg(input int n, input int sync_at);
        int base;
        start_run(n, sync_at, base);
        if (sync_at >= 0) begin
            wait_latches(base + sync_at + 1, 3000);
            @(negedge clk);
            frame_sync_in = 1'b1;
            @(negedge clk);
            frame_sync_in = 1'b0;
            repeat (2) @(negedge clk);
            frame_sync_in = 1'b1;
            @(negedge clk);
            frame_sync_in = 1'b0;
        end
        wait_latches(base + n, 20000);
        enable_in = 1'b0;
        wait_idle(3000);
        chk_eq("idle_oe_n", hub75_oe_n_out, 1);
        repeat (30) @(negedge clk);
        chk_eq("idle_busy", busy_out, 0);
        chk_eq("shift_queue_drained", exp_shift.size(), 0);
        chk_eq("disp_queue_drained", exp_disp.size(), 0);
    endtask

    initial begin
        int base;
        #2;
        chk_eq("rst_addr", hub75_addr_out, 0);
        chk_eq("rst_latch", hub75_latch_out, 0);
        chk_eq("rst_oe_n", hub75_oe_n_out, 1);
        chk_eq("rst_shift_start", shift_start_out, 0);
        chk_eq("rst_shift_row", shift_row_out, 0);
        chk_eq("rst_shift_plane", shift_plane_out, 0);
        chk_eq("rst_frame_done", frame_done_out, 0);
        chk_eq("rst_busy", busy_out, 0);
        repeat (2) @(negedge clk);
        rst_in = 1'b1;
        repeat (5) @(negedge clk);
        chk_eq("idle_without_enable", busy_out, 0);

        shift_lat = 20;
        run_seg(4, -1);

        shift_lat = 3;
        fast = 1;
        run_seg(99, -1);
        fast = 0;

        shift_lat = 100;
        run_seg(3, -1);

        shift_lat = int'($urandom_range(40, 2));
        run_seg(23, 15);

        rand_lat = 1;
        run_seg(int'($urandom_range(12, 5)), -1);
        rand_lat = 0;

        shift_lat = 6;
        start_run(10, -1, base);
        wait_latches(base + 4, 3000);
        repeat (3) @(negedge clk);
        #1 rst_in = 1'b0;
        #1;
        chk_eq("async_oe_n", hub75_oe_n_out, 1);
        chk_eq("async_latch", hub75_latch_out, 0);
        chk_eq("async_addr", hub75_addr_out, 0);
        chk_eq("async_busy", busy_out, 0);
        chk_eq("async_shift_start", shift_start_out, 0);
        exp_shift.delete();
        exp_disp.delete();
        enable_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_in = 1'b1;
        repeat (30) @(negedge clk);
        chk_eq("post_reset_idle", busy_out, 0);
        chk_eq("post_reset_oe_n", hub75_oe_n_out, 1);

        shift_lat = 5;
        run_seg(3, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
